// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Shares one register-file write port between the in-order writeback stage
// and a multi-cycle execution unit. MC results wait in a small FIFO. A wait
// counter stalls WB once the FIFO head has been denied too long. A busy
// scoreboard tracks the destinations of in-flight MC operations.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset,
    input  logic                            i_WB_wEnable,
    input  logic [4:0]                      i_WB_wAddr,
    input  logic [DATA_WIDTH-1:0]           i_WB_wData,
    input  logic                            i_MC_Valid,
    output logic                            o_MC_Ready,
    input  logic [4:0]                      i_MC_wAddr,
    input  logic [DATA_WIDTH-1:0]           i_MC_wData,
    input  logic                            i_Issue_Valid,
    input  logic [4:0]                      i_Issue_Rd,
    output logic                            o_Issue_Ready,
    input  logic [4:0]                      i_rAddr_1,
    input  logic [4:0]                      i_rAddr_2,
    output logic                            o_Hazard_1,
    output logic                            o_Hazard_2,
    output logic                            o_StallWB,
    output logic                            o_wEnable,
    output logic [4:0]                      o_wAddr,
    output logic [DATA_WIDTH-1:0]           o_wData,
    output logic [$clog2(FIFO_DEPTH):0]     o_Pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [4:0]            fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [WW-1:0]         wait_cnt;
    logic [31:1]           busy_q;
    logic [31:0]           busy_vec;

    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  wb_req;
    logic                  wb_grant;
    logic                  mc_grant;
    logic [4:0]            head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  issue_set;

    // x0 is hard-wired never busy, so it sits outside the register
    assign busy_vec   = {busy_q, 1'b0};

    assign fifo_empty = (count == '0);
    assign o_MC_Ready = (count < CW'(FIFO_DEPTH));
    assign push       = i_MC_Valid && o_MC_Ready;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    assign o_StallWB  = (wait_cnt == WW'(MAX_WAIT));
    assign o_Pending  = count;

    // A write to x0 is not a real request and must never take the port
    assign wb_req     = i_WB_wEnable && (i_WB_wAddr != 5'd0);
    assign wb_grant   = wb_req && !o_StallWB;
    // wait_cnt only becomes nonzero while the FIFO holds an entry, so a stall
    // always has a head to grant
    assign mc_grant   = !fifo_empty && (o_StallWB || !wb_req);
    assign pop        = mc_grant;

    assign issue_set     = i_Issue_Valid && o_Issue_Ready && (i_Issue_Rd != 5'd0);
    assign o_Issue_Ready = ~busy_vec[i_Issue_Rd];
    assign o_Hazard_1    = busy_vec[i_rAddr_1];
    assign o_Hazard_2    = busy_vec[i_rAddr_2];

    // Write-port mux; enable is gated by reset so nothing writes during reset
    always_comb begin
        o_wEnable = 1'b0;
        o_wAddr   = 5'd0;
        o_wData   = '0;
        if (mc_grant) begin
            o_wAddr = head_addr;
            o_wData = head_data;
        end else if (wb_grant) begin
            o_wAddr = i_WB_wAddr;
            o_wData = i_WB_wData;
        end
        o_wEnable = i_Reset && (mc_grant || wb_grant) && (o_wAddr != 5'd0);
    end

    // MC result FIFO: storage, pointers and occupancy
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= 5'd0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= i_MC_wAddr;
                fifo_data[wr_ptr] <= i_MC_wData;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts cycles the head is present but not granted
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wait_cnt <= '0;
        end else if (pop || fifo_empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Busy scoreboard: clear on pop first so a same-edge issue re-sets the bit
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            busy_q <= '0;
        end else begin
            logic [31:0] nxt;
            nxt = busy_vec;
            if (pop) begin
                nxt[head_addr] = 1'b0;
            end
            if (issue_set) begin
                nxt[i_Issue_Rd] = 1'b1;
            end
            busy_q <= nxt[31:1];
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage (WB) and a multi-cycle execution unit (MC, e.g. divider or long-latency load).
- Buffers MC results in a small FIFO and enforces a starvation limit by stalling WB.
- Keeps a per-register busy scoreboard so decode can detect RAW/WAW hazards on MC destinations.
- Sits between the WB/MC stages and the register file. Its write-port outputs drive the register file's write enable, address and data directly.

Parameters:
- FIFO_DEPTH, 2, MC result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a non-empty FIFO head may be denied before WB is stalled
- DATA_WIDTH, 32, register data width

Ports:
- i_Clk  in  1  clock; state updates on posedge
- i_Reset  in  1  reset, asynchronous, active-low
- i_WB_wEnable  in  1  WB write request
- i_WB_wAddr  in  5  WB destination
- i_WB_wData  in  DATA_WIDTH  WB data
- i_MC_Valid  in  1  MC result valid
- o_MC_Ready  out  1  FIFO can accept an MC result
- i_MC_wAddr  in  5  MC destination
- i_MC_wData  in  DATA_WIDTH  MC data
- i_Issue_Valid  in  1  decode issues an MC op
- i_Issue_Rd  in  5  destination of the issued MC op
- o_Issue_Ready  out  1  issue permitted (i_Issue_Rd not busy)
- i_rAddr_1  in  5  decode source register 1
- i_rAddr_2  in  5  decode source register 2
- o_Hazard_1  out  1  source 1 has a pending MC write
- o_Hazard_2  out  1  source 2 has a pending MC write
- o_StallWB  out  1  pipeline must freeze WB this cycle
- o_wEnable  out  1  register-file write enable
- o_wAddr  out  5  register-file write address
- o_wData  out  DATA_WIDTH  register-file write data
- o_Pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (i_Reset low, asynchronous):
  - FIFO emptied, all 32 busy bits cleared, wait counter cleared.
  - Outputs: o_MC_Ready=1, o_Issue_Ready=1, o_Hazard_1/2=0, o_StallWB=0, o_Pending=0.
  - o_wEnable is forced to 0 while reset is asserted, regardless of inputs.
- MC accept: on posedge with i_MC_Valid && o_MC_Ready, push {wAddr, wData}.
  - o_MC_Ready = (count < FIFO_DEPTH), driven from registered count.
  - No bypass: an MC result reaches the write port no earlier than the cycle after acceptance.
- Grant, combinational per cycle:
  1. o_StallWB=1: grant MC head.
  2. Otherwise, WB requesting with nonzero address: grant WB.
  3. Otherwise, FIFO not empty: grant MC head.
  4. Otherwise, no grant: o_wEnable=0.
- WB with i_WB_wAddr=0 counts as no request and never consumes the port.
- o_wEnable=1 only if the granted address ≠ 0.
- An MC head with address 0 is still popped when granted, but o_wEnable stays 0.
- Pop: at posedge, when MC is granted. Push and pop may occur on the same edge: count unchanged, pointers wrap modulo FIFO_DEPTH.
- Wait counter:
  - Cleared on pop or when the FIFO is empty.
  - Otherwise increments each posedge while the head is denied, saturating at MAX_WAIT.
- o_StallWB = (wait_cnt == MAX_WAIT), from registers only. The pipeline holds WB and re-presents it next cycle. The arbiter ignores the WB request while o_StallWB=1.
- Scoreboard busy[31:1]; busy[0] is constant 0.
  - Issue accepted when i_Issue_Valid && o_Issue_Ready, and sets busy[i_Issue_Rd] at posedge if Rd ≠ 0.
  - o_Issue_Ready = ~busy[i_Issue_Rd]. Issue while not ready is ignored.
  - An MC pop clears busy[popped address] at posedge.
  - Set and clear of the same register on the same edge: set wins.
- o_Hazard_n = busy[i_rAddr_n], combinational. Address 0 never reports a hazard.
- WB writes to a busy register are not checked. Decode must prevent them via o_Issue_Ready and o_Hazard.
- A mid-operation reset discards FIFO contents and pending busy bits. No write is issued for discarded entries.

Test Plan:
- Reset with i_WB_wEnable=1, addr 5 held → o_wEnable=0 during reset; o_MC_Ready=1; o_Pending=0. After release, o_wEnable=1, o_wAddr=5.
- Issue Rd=7; MC returns x7=0xDEADBEEF with WB idle → busy[7]=1 and o_Hazard_1=1 for rAddr_1=7. One cycle after acceptance: o_wEnable=1, o_wAddr=7, o_wData=0xDEADBEEF. Next cycle o_Hazard_1=0.
- WB writes every cycle while MC pushes x3=0x11 → MC head denied for 4 cycles. 5th cycle: o_StallWB=1 and x3=0x11 written. o_StallWB drops the following cycle.
- Push 2 MC results with WB busy → o_Pending=2, o_MC_Ready=0; a third i_MC_Valid is not accepted. After one pop, push and pop on the same edge keep o_Pending=1.
- Issue Rd=0 and MC result to x0 → o_Issue_Ready stays 1, no hazard, entry popped with o_wEnable=0. Issue Rd=9 while busy[9] → o_Issue_Ready=0, scoreboard unchanged.
- Same-edge pop of x4 and new issue of Rd=4 → busy[4] remains 1.
